// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the configurable UART receiver.
// Reusable by a future transmitter in the same slice.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_t;

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Mod-(dvsr+1) oversample tick generator.
// The divisor is captured only while load_en is high.
module uart_baud_gen #(
    parameter int DVSR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              load_en,
    output logic              s_tick
);

    logic [DVSR_W-1:0] cnt;
    logic [DVSR_W-1:0] dvsr_l;

    // >= keeps the counter bounded if a smaller divisor is loaded mid-count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            dvsr_l <= '0;
        end else begin
            if (load_en)
                dvsr_l <= dvsr;
            if (cnt >= dvsr_l)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    assign s_tick = (cnt == dvsr_l);

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with runtime parity/stop/baud selection
// and a one-entry read buffer carrying error status.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT   = 8,
    parameter int OS     = 16,
    parameter int DVSR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic              rx,
    input  logic              rd,
    output logic [DBIT-1:0]   rx_dout,
    output logic              rx_valid,
    output logic              rx_done_tick,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              break_det
);

    localparam int SW = $clog2(OS);
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OS / 2 - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    rx_state_t state, state_d;
    logic [SW-1:0]   s, s_d;
    logic [NW-1:0]   n, n_d;
    logic [DBIT-1:0] b, b_d;
    logic [1:0]      par_l, par_d;
    logic            stop2_l, stop2_d;
    logic            perr_l, perr_d;
    logic            fe_l, fe_d;
    logic            pbit_l, pbit_d;
    logic [1:0]      sync;
    logic            rx_s;
    logic            s_tick;
    logic            stop_last;
    logic            fe_now;
    logic            frame_done;
    logic            brk;
    logic            load;

    uart_baud_gen #(.DVSR_W(DVSR_W)) u_baud (
        .clk    (clk),
        .reset  (reset),
        .dvsr   (dvsr),
        .load_en(state == IDLE),
        .s_tick (s_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sync <= 2'b11;
        else
            sync <= {sync[0], rx};
    end

    assign rx_s = sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            s       <= '0;
            n       <= '0;
            b       <= '0;
            par_l   <= PAR_NONE;
            stop2_l <= 1'b0;
            perr_l  <= 1'b0;
            fe_l    <= 1'b0;
            pbit_l  <= 1'b0;
        end else begin
            state   <= state_d;
            s       <= s_d;
            n       <= n_d;
            b       <= b_d;
            par_l   <= par_d;
            stop2_l <= stop2_d;
            perr_l  <= perr_d;
            fe_l    <= fe_d;
            pbit_l  <= pbit_d;
        end
    end

    always_comb begin
        state_d = state;
        s_d     = s;
        n_d     = n;
        b_d     = b;
        par_d   = par_l;
        stop2_d = stop2_l;
        perr_d  = perr_l;
        fe_d    = fe_l;
        pbit_d  = pbit_l;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                    n_d     = '0;
                    par_d   = parity_mode;
                    stop2_d = stop2;
                    perr_d  = 1'b0;
                    fe_d    = 1'b0;
                    pbit_d  = 1'b0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == S_MID) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        s_d = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        s_d = '0;
                        b_d = {rx_s, b[DBIT-1:1]};
                        if (n == N_LAST) begin
                            n_d     = '0;
                            state_d = par_enabled(par_l) ? PARITY : STOP;
                        end else begin
                            n_d = n + 1'b1;
                        end
                    end else begin
                        s_d = s + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        s_d     = '0;
                        pbit_d  = rx_s;
                        perr_d  = ((^b) ^ rx_s) != (par_l == PAR_ODD);
                        state_d = STOP;
                    end else begin
                        s_d = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        s_d  = '0;
                        fe_d = fe_now;
                        if (frame_done) begin
                            n_d     = '0;
                            state_d = brk ? BRK_WAIT : IDLE;
                        end else begin
                            n_d = 1'b1;
                        end
                    end else begin
                        s_d = s + 1'b1;
                    end
                end
            end
            BRK_WAIT: begin
                if (rx_s)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // n counts stop bits in STOP: 0 = first (checked), 1 = second (timed only)
    always_comb begin
        stop_last    = (state == STOP) && s_tick && (s == S_LAST);
        fe_now       = (n == '0) ? ~rx_s : fe_l;
        frame_done   = stop_last && ((n != '0) || !stop2_l);
        brk          = frame_done && fe_now && (b == '0) && !pbit_l;
        load         = frame_done && (!rx_valid || rd);
        rx_done_tick = load;
        break_det    = brk;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_dout     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (frame_done) begin
            if (load) begin
                rx_dout     <= b;
                rx_valid    <= 1'b1;
                parity_err  <= perr_l;
                frame_err   <= fe_now;
                overrun_err <= 1'b0;
            end else begin
                overrun_err <= 1'b1;
            end
        end else if (rd) begin
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: vector table plus scoreboard
// of expected buffered frames, with hand sequences for corner cases.
module tb_uart_rx_cfg;

    localparam int DBIT   = 8;
    localparam int OS     = 16;
    localparam int DVSR_W = 11;
    localparam int BIT    = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [DVSR_W-1:0] dvsr;
    logic [1:0]        parity_mode;
    logic              stop2;
    logic              rx;
    logic              rd;
    logic [DBIT-1:0]   rx_dout;
    logic              rx_valid;
    logic              rx_done_tick;
    logic              parity_err;
    logic              frame_err;
    logic              overrun_err;
    logic              break_det;

    uart_rx_cfg #(.DBIT(DBIT), .OS(OS), .DVSR_W(DVSR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .dvsr        (dvsr),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .rx          (rx),
        .rd          (rd),
        .rx_dout     (rx_dout),
        .rx_valid    (rx_valid),
        .rx_done_tick(rx_done_tick),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .break_det   (break_det)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] pmode;
        logic       s2;
        logic       pbit;
        logic       stop_ok;
        logic [7:0] e_dout;
        logic       e_perr;
        logic       e_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] dout;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    vec_t vecs[8];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int brk_cnt   = 0;
    int done_cyc  = 0;
    int stop_cyc  = 0;
    logic pend    = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard monitor: samples 2 time units after the falling edge.
    always @(negedge clk) begin
        #2;
        if (pend) begin
            pend = 1'b0;
            check("sb_dout", rx_dout, cur.dout);
            check("sb_valid", rx_valid, 1);
            check("sb_perr", parity_err, cur.perr);
            check("sb_ferr", frame_err, cur.ferr);
            check("sb_ovr", overrun_err, cur.ovr);
        end
        if (rx_done_tick) begin
            done_cnt++;
            done_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                cur  = sb.pop_front();
                pend = 1'b1;
            end
        end
        if (break_det) brk_cnt++;
    end

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic [1:0] pm,
                              input logic s2, input logic pbit,
                              input logic stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        if (pm == 2'b01 || pm == 2'b10) send_bit(pbit);
        stop_cyc = cyc;
        if (stop_ok) begin
            send_bit(1'b1);
        end else begin
            rx = 1'b0;
            repeat (48) @(negedge clk);
            rx = 1'b1;
            repeat (BIT - 48) @(negedge clk);
        end
        if (s2) send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic do_rd();
        @(negedge clk) rd = 1'b1;
        @(negedge clk) rd = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic pe,
                        input logic fe, input logic ov);
        exp_t e;
        e.dout = d;
        e.perr = pe;
        e.ferr = fe;
        e.ovr  = ov;
        sb.push_back(e);
    endtask

    initial begin
        int d0;
        int b0;
        int lat;
        logic found;

        vecs[0] = '{8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 2'd1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'h07, 2'd1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 2'd2, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 2'd2, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[5] = '{8'h5A, 2'd3, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[6] = '{8'h55, 2'd0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
        vecs[7] = '{8'h00, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

        reset = 1'b1;
        rx = 1'b1;
        rd = 1'b0;
        dvsr = 11'd3;
        parity_mode = 2'b00;
        stop2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", rx_dout, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_done", rx_done_tick, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun_err, 0);
        check("rst_brk", break_det, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            parity_mode = vecs[i].pmode;
            stop2 = vecs[i].s2;
            d0 = done_cnt;
            push(vecs[i].e_dout, vecs[i].e_perr, vecs[i].e_ferr, 1'b0);
            send_frame(vecs[i].data, vecs[i].pmode, vecs[i].s2,
                       vecs[i].pbit, vecs[i].stop_ok);
            check("vec_done_count", done_cnt - d0, 1);
            lat = done_cyc - stop_cyc;
            if (vecs[i].s2)
                check("stop2_latency", (lat >= 84 && lat <= 110), 1);
            else
                check("stop1_latency", (lat >= 20 && lat <= 46), 1);
            do_rd();
            check("rd_valid", rx_valid, 0);
            check("rd_perr", parity_err, 0);
            check("rd_ferr", frame_err, 0);
        end

        // overrun: second frame dropped while buffer is full
        parity_mode = 2'b00;
        stop2 = 1'b0;
        d0 = done_cnt;
        push(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1);
        check("ovr_done_count", done_cnt - d0, 1);
        check("ovr_dout", rx_dout, 8'h11);
        check("ovr_flag", overrun_err, 1);
        check("ovr_valid", rx_valid, 1);

        // rd coincident with completion
        push(8'h22, 1'b0, 1'b0, 1'b0);
        found = 1'b0;
        fork
            send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    if (dut.frame_done) begin
                        found = 1'b1;
                        break;
                    end
                end
                if (found) begin
                    #1 rd = 1'b1;
                    @(negedge clk) rd = 1'b0;
                end
            end
        join
        check("simul_found", found, 1);
        check("simul_dout", rx_dout, 8'h22);
        check("simul_ovr", overrun_err, 0);
        do_rd();

        // break: 12 bit times low
        check("brk_pre_valid", rx_valid, 0);
        push(8'h00, 1'b0, 1'b1, 1'b0);
        b0 = brk_cnt;
        d0 = done_cnt;
        rx = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        check("brk_pulses", brk_cnt - b0, 1);
        check("brk_done_count", done_cnt - d0, 1);
        check("brk_no_restart_ovr", overrun_err, 0);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        do_rd();
        push(8'h5A, 1'b0, 1'b0, 1'b0);
        d0 = done_cnt;
        send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1);
        check("post_brk_done", done_cnt - d0, 1);

        // short low glitch must be rejected
        d0 = done_cnt;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("glitch_done", done_cnt - d0, 0);
        check("glitch_dout", rx_dout, 8'h5A);
        check("glitch_ovr", overrun_err, 0);

        // async reset mid-DATA with a full buffer
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b1;
        #1;
        check("mrst_dout", rx_dout, 0);
        check("mrst_valid", rx_valid, 0);
        check("mrst_done", rx_done_tick, 0);
        check("mrst_perr", parity_err, 0);
        check("mrst_ferr", frame_err, 0);
        check("mrst_ovr", overrun_err, 0);
        check("mrst_brk", break_det, 0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (BIT) @(negedge clk);
        push(8'h81, 1'b0, 1'b0, 1'b0);
        d0 = done_cnt;
        send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b1);
        check("post_rst_done", done_cnt - d0, 1);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Next-generation UART receiver. Oversampled and parametrised in data width.
- Adds runtime-selectable parity (none/even/odd), 1 or 2 stop bits, and a runtime baud divisor.
- Adds a one-entry read buffer with parity, framing, overrun and break status.
- Sits beside the existing uart top and consumes its tx line in loopback benches.

Parameters:
DBIT, 8, data bits per frame (5..9), LSB first
OS, 16, oversample ticks per bit (even, >=4)
DVSR_W, 11, width of the baud divisor input

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
dvsr  in  DVSR_W  baud tick period minus 1 (tick every dvsr+1 clocks)
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
stop2  in  1  1 = two stop bits expected
rx  in  1  serial input, idle high, asynchronous
rd  in  1  consume buffered byte; clears rx_valid and all status flags
rx_dout  out  DBIT  received data word
rx_valid  out  1  buffer holds unread data
rx_done_tick  out  1  one-cycle pulse when a frame is written to the buffer
parity_err  out  1  parity mismatch on buffered frame
frame_err  out  1  first stop bit sampled 0 on buffered frame
overrun_err  out  1  a frame completed while the buffer was full
break_det  out  1  one-cycle pulse on break (all-zero frame including stop)

Behaviour:
- Reset (async, active-high): FSM to IDLE; all outputs 0; rx synchroniser flops to 1; baud counter 0.
- rx passes through a 2-FF synchroniser, so the detection latency is 2 clocks.
- Baud generator: counter 0..dvsr_l, s_tick high for one clock when count==dvsr_l. dvsr=0 gives a tick every clock. dvsr_l reloads from dvsr only while the FSM is IDLE.
- parity_mode and stop2 are latched on start detection. Changes mid-frame are ignored.
- FSM states and transitions:
  - IDLE: synced rx==0 -> START, tick count s=0.
  - START: on s_tick, when s==OS/2-1, rx==0 -> DATA with s=0, n=0; rx==1 -> IDLE (glitch rejected, no flags).
  - DATA: on s_tick, when s==OS-1, shift rx into the MSB of the shift register (LSB-first result). When n==DBIT-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: sample at s==OS-1. Even mode: error if XOR(data,bit)!=0. Odd mode: error if XOR(data,bit)!=1. Then -> STOP.
  - STOP: sample the first stop bit at s==OS-1. A second stop bit (stop2) is timed for a further OS ticks but not checked. The frame then completes and the FSM returns to IDLE; with stop2 the FSM goes to IDLE after 2*OS ticks.
  - BRK_WAIT: stays until synced rx==1, then -> IDLE.
- Break: data all 0, parity bit 0 (if enabled) and first stop bit 0. On break:
  - frame_err set and break_det pulsed on the completion cycle;
  - the frame is still buffered, with rx_dout=0;
  - the FSM goes to BRK_WAIT instead of IDLE.
- Frame completion, cycle C:
  - Buffer empty, or rd asserted in C: rx_dout, parity_err and frame_err load; rx_valid=1; rx_done_tick=1 in C. overrun_err is not set.
  - Buffer full and no rd: the new frame is discarded, the old rx_dout is kept, and overrun_err is set (sticky). rx_done_tick stays low.
- rd with no completion in the same cycle: rx_valid, parity_err, frame_err and overrun_err clear next cycle. rd while empty has no effect.
- Reset mid-frame: immediate abort, no partial data buffered.

Decomposition:
- uart_pkg holds:
  - parity constants PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10;
  - FSM state encodings IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- One sub-module, uart_baud_gen. It is a mod-(dvsr+1) counter with clk, reset, dvsr, load_en, and s_tick out; it is reusable by a future transmitter.

Test Plan:
- dvsr=3 (64 clk/bit), parity none, send 8'hA5 8N1 -> rx_done_tick one pulse, rx_dout=8'hA5, rx_valid=1, all errors 0.
- parity_mode=01, send 8'h07 with parity bit 0 -> parity_err=1, rx_dout=8'h07. Same frame with parity bit 1 -> parity_err=0.
- parity_mode=10, stop2=1, send 8'h3C, then rd -> rx_valid, parity_err and frame_err all 0 one cycle after rd. The next start bit is accepted only after 2 stop bits.
- Send 8'h11 then 8'h22 without rd -> rx_dout stays 8'h11, overrun_err=1, single rx_done_tick. A simultaneous rd/completion variant -> rx_dout=8'h22, overrun_err=0.
- Hold rx low for 12 bit times -> break_det pulse, frame_err=1, rx_dout=0, FSM stays in BRK_WAIT until rx high, then 8'h5A received correctly.
- Low glitch of 20 clocks (< OS/2 ticks at dvsr=3) -> no rx_done_tick. Assert reset mid-DATA of 8'hFF -> all outputs 0, the next frame 8'h81 is received correctly.
